// File: rtl/me_pkg.sv
// Shared types and width helpers for the full-search SAD motion-estimation engine.
package me_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FLUSH,
    CMP,
    DONE
  } state_e;

  function automatic int sad_w(input int pix_w, input int blk);
    return pix_w + 2 * $clog2(blk);
  endfunction

  function automatic int sr_w(input int blk, input int ny);
    return $clog2(blk + ny - 1);
  endfunction

endpackage

// File: rtl/me_sad_pe.sv
// One processing element: registered accumulator of |ref - srch| for a single
// horizontal candidate offset.
module me_sad_pe #(
  parameter int PIX_W = 8,
  parameter int SAD_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_ref,
  input  logic [PIX_W-1:0] i_srch,
  output logic [SAD_W-1:0] o_acc
);

  logic [PIX_W-1:0] diff;
  logic [SAD_W-1:0] acc_d;
  logic [SAD_W-1:0] acc_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    acc_d = acc_q;
    diff  = (i_ref >= i_srch) ? (i_ref - i_srch) : (i_srch - i_ref);
    if (i_clr) begin
      acc_d = '0;
    end else if (i_en) begin
      acc_d = acc_q + SAD_W'(diff);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here
  // would make the result depend on process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/me_sad_engine.sv
// Full-search block-matching SAD engine: NPE parallel PEs, one vertical offset per pass.
// Optional early pass termination is built when ME_EARLY_TERM_EN is defined.
module me_sad_engine
  import me_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int BLK   = 16,
  parameter int NPE   = 16,
  parameter int NY    = 16,
  parameter int MV_W  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic [$clog2(BLK)-1:0]        o_r_row,
  output logic [$clog2(BLK)-1:0]        o_r_col,
  input  logic [PIX_W-1:0]              i_ref_pix,
  output logic [sr_w(BLK, NY)-1:0]      o_s_row,
  output logic [$clog2(BLK)-1:0]        o_s_col,
  input  logic [NPE*PIX_W-1:0]          i_search_win,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [sad_w(PIX_W, BLK)-1:0]  o_best_sad,
  output logic signed [MV_W-1:0]        o_mv_x,
  output logic signed [MV_W-1:0]        o_mv_y
);

  localparam int LB    = $clog2(BLK);
  localparam int SAD_W = sad_w(PIX_W, BLK);
  localparam int SR_W  = sr_w(BLK, NY);
  localparam int NPIX  = BLK * BLK;
  localparam int CNT_W = $clog2((NPIX > NPE) ? NPIX : NPE);
  localparam int PE_W  = $clog2(NPE);
  localparam int DY_W  = $clog2(NY);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] LAST_PE  = CNT_W'(NPE - 1);
  localparam logic [DY_W-1:0]  LAST_DY  = DY_W'(NY - 1);

  state_e                  state_d, state_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic [DY_W-1:0]         dy_d, dy_q;
  logic [SAD_W-1:0]        best_d, best_q;
  logic                    best_valid_d, best_valid_q;
  logic signed [MV_W-1:0]  mv_x_d, mv_x_q;
  logic signed [MV_W-1:0]  mv_y_d, mv_y_q;
  logic                    valid_d, valid_q;

  logic [SAD_W-1:0]        acc [NPE];
  logic [SAD_W-1:0]        cur_acc;
  logic [PE_W-1:0]         k_sel;
  logic                    pe_clr;
  logic                    pe_en;
  logic                    pass_end;
  logic                    abort;

  for (genvar k = 0; k < NPE; k++) begin : g_pe
    me_sad_pe #(
      .PIX_W (PIX_W),
      .SAD_W (SAD_W)
    ) u_pe (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_clr  (pe_clr),
      .i_en   (pe_en),
      .i_ref  (i_ref_pix),
      .i_srch (i_search_win[k*PIX_W +: PIX_W]),
      .o_acc  (acc[k])
    );
  end

`ifdef ME_EARLY_TERM_EN
  // A pass can no longer win once every partial sum already reaches the best;
  // partial sums only grow, so aborting never changes the result.
  always_comb begin
    abort = (state_q == ACCUM) && (cnt_q >= CNT_W'(2)) && best_valid_q;
    for (int k = 0; k < NPE; k++) begin
      if (acc[k] < best_q) abort = 1'b0;
    end
  end
`else
  assign abort = 1'b0;
`endif

  assign k_sel   = cnt_q[PE_W-1:0];
  assign cur_acc = acc[k_sel];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dy_d         = dy_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    mv_x_d       = mv_x_q;
    mv_y_d       = mv_y_q;
    valid_d      = valid_q;
    pe_clr       = 1'b0;
    pe_en        = 1'b0;
    pass_end     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          pe_clr       = 1'b1;
          cnt_d        = '0;
          dy_d         = '0;
          best_d       = '1;
          best_valid_d = 1'b0;
          state_d      = ACCUM;
        end
      end
      ACCUM: begin
        // Pixel j-1 arrives during cycle j, so cycle 0 has nothing to add.
        pe_en = (cnt_q != '0);
        if (abort) begin
          pass_end = 1'b1;
        end else if (cnt_q == LAST_PIX) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        pe_en   = 1'b1;
        cnt_d   = '0;
        state_d = CMP;
      end
      CMP: begin
        // Strict less-than keeps the earliest candidate on ties.
        if (cur_acc < best_q) begin
          best_d       = cur_acc;
          best_valid_d = 1'b1;
          mv_x_d       = MV_W'(int'(k_sel) - NPE / 2);
          mv_y_d       = MV_W'(int'(dy_q) - NY / 2);
        end
        if (cnt_q == LAST_PE) begin
          pass_end = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pass_end) begin
      pe_clr = 1'b1;
      cnt_d  = '0;
      if (dy_q == LAST_DY) begin
        valid_d = 1'b1;
        state_d = DONE;
      end else begin
        dy_d    = dy_q + 1'b1;
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dy_q         <= '0;
      best_q       <= '1;
      best_valid_q <= 1'b0;
      mv_x_q       <= '0;
      mv_y_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dy_q         <= dy_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      mv_x_q       <= mv_x_d;
      mv_y_q       <= mv_y_d;
      valid_q      <= valid_d;
    end
  end

  logic in_accum;
  logic result_ok;

  assign in_accum  = (state_q == ACCUM);
  assign result_ok = valid_q & best_valid_q;

  assign o_busy     = (state_q != IDLE);
  assign o_r_row    = in_accum ? cnt_q[2*LB-1:LB] : '0;
  assign o_r_col    = in_accum ? cnt_q[LB-1:0]    : '0;
  assign o_s_col    = in_accum ? cnt_q[LB-1:0]    : '0;
  assign o_s_row    = in_accum ? (SR_W'(dy_q) + SR_W'(cnt_q[2*LB-1:LB])) : '0;
  assign o_valid    = valid_q;
  assign o_best_sad = result_ok ? best_q : '0;
  assign o_mv_x     = result_ok ? mv_x_q : '0;
  assign o_mv_y     = result_ok ? mv_y_q : '0;

endmodule

// File: tb/tb_me_sad_engine.sv
// Self-checking bench for me_sad_engine: randomized images scored by a direct
// full-search SAD model; also covers handshake hold and mid-run reset.
module tb_me_sad_engine;

  localparam int PIX_W = 8;
  localparam int BLK   = 16;
  localparam int NPE   = 16;
  localparam int NY    = 16;
  localparam int MV_W  = 8;
  localparam int LB    = $clog2(BLK);
  localparam int SAD_W = PIX_W + 2 * LB;
  localparam int SR_W  = $clog2(BLK + NY - 1);
  localparam int SH    = BLK + NY - 1;
  localparam int SW    = BLK + NPE - 1;
  localparam int NPIX  = BLK * BLK;

  logic                   i_clk;
  logic                   i_rst_n;
  logic                   i_start;
  logic                   o_busy;
  logic [LB-1:0]          o_r_row;
  logic [LB-1:0]          o_r_col;
  logic [PIX_W-1:0]       i_ref_pix;
  logic [SR_W-1:0]        o_s_row;
  logic [LB-1:0]          o_s_col;
  logic [NPE*PIX_W-1:0]   i_search_win;
  logic                   o_valid;
  logic                   i_ready;
  logic [SAD_W-1:0]       o_best_sad;
  logic signed [MV_W-1:0] o_mv_x;
  logic signed [MV_W-1:0] o_mv_y;

  me_sad_engine #(
    .PIX_W(PIX_W), .BLK(BLK), .NPE(NPE), .NY(NY), .MV_W(MV_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_r_row     (o_r_row),
    .o_r_col     (o_r_col),
    .i_ref_pix   (i_ref_pix),
    .o_s_row     (o_s_row),
    .o_s_col     (o_s_col),
    .i_search_win(i_search_win),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_best_sad  (o_best_sad),
    .o_mv_x      (o_mv_x),
    .o_mv_y      (o_mv_y)
  );

  int ref_mem [BLK][BLK];
  int srch    [SH][SW];
  int total = 0;
  int bad   = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Memories answer one cycle after the address, driven 1 time unit past the edge.
  always @(posedge i_clk) begin
    int rr, rc, sr, sc;
    logic [NPE*PIX_W-1:0] w;
    rr = int'(o_r_row);
    rc = int'(o_r_col);
    sr = int'(o_s_row);
    sc = int'(o_s_col);
    #1;
    i_ref_pix = PIX_W'(ref_mem[rr][rc]);
    for (int k = 0; k < NPE; k++) w[k*PIX_W +: PIX_W] = PIX_W'(srch[sr][sc+k]);
    i_search_win = w;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode: 0 full-range noise, 1 flat 10, 2 ref=255/search=0, 3 low-range noise (many ties)
  task automatic fill(input int mode, input bit place, input int dx, input int dy);
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        case (mode)
          1: ref_mem[r][c] = 10;
          2: ref_mem[r][c] = 255;
          3: ref_mem[r][c] = int'($urandom_range(0, 3));
          default: ref_mem[r][c] = int'($urandom_range(0, 255));
        endcase
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        case (mode)
          1: srch[r][c] = 10;
          2: srch[r][c] = 0;
          3: srch[r][c] = int'($urandom_range(0, 3));
          default: srch[r][c] = int'($urandom_range(0, 255));
        endcase
    if (place)
      for (int r = 0; r < BLK; r++)
        for (int c = 0; c < BLK; c++)
          srch[dy + NY/2 + r][dx + NPE/2 + c] = ref_mem[r][c];
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Brute-force search: scan dy then dx ascending, keep the first strict minimum.
  task automatic model(output int bsad, output int bx, output int by, output int lat);
    int  sad [NPE];
    int  best;
    bit  bv;
    bit  aborted;
    best = 1 << 30;
    bv   = 1'b0;
    lat  = 0;
    bx   = 0;
    by   = 0;
    for (int dy = 0; dy < NY; dy++) begin
      for (int k = 0; k < NPE; k++) begin
        sad[k] = 0;
        for (int r = 0; r < BLK; r++)
          for (int c = 0; c < BLK; c++)
            sad[k] += absd(ref_mem[r][c], srch[dy + r][k + c]);
      end
      aborted = 1'b0;
`ifdef ME_EARLY_TERM_EN
      if (bv) begin
        int part [NPE];
        for (int k = 0; k < NPE; k++) part[k] = 0;
        for (int j = 2; j < NPIX && !aborted; j++) begin
          bit all_ge;
          int p;
          p = j - 2;
          all_ge = 1'b1;
          for (int k = 0; k < NPE; k++) begin
            part[k] += absd(ref_mem[p / BLK][p % BLK], srch[dy + p / BLK][k + p % BLK]);
            if (part[k] < best) all_ge = 1'b0;
          end
          if (all_ge) begin
            aborted = 1'b1;
            lat += j + 1;
          end
        end
      end
`endif
      if (!aborted) begin
        lat += NPIX + 1 + NPE;
        for (int k = 0; k < NPE; k++)
          if (sad[k] < best) begin
            best = sad[k];
            bv   = 1'b1;
            bx   = k - NPE / 2;
            by   = dy - NY / 2;
          end
      end
    end
    bsad = best;
  endtask

  task automatic run(input string tag, input bit poke, input int hold);
    int bs, bx, by, lat, n;
    bit seen;
    model(bs, bx, by, lat);
    @(negedge i_clk);
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20000) begin
      @(posedge i_clk);
      #1;
      n++;
      i_start = (poke && n == 100);
      if (o_valid === 1'b1) seen = 1'b1;
    end
    i_start = 1'b0;
    check({tag, "_latency"}, n, lat);
    check({tag, "_sad"}, o_best_sad, bs);
    check({tag, "_mvx"}, $signed(o_mv_x), bx);
    check({tag, "_mvy"}, $signed(o_mv_y), by);
    for (int i = 0; i < hold; i++) begin
      i_start = (i == 5);
      @(posedge i_clk);
      #1 i_start = 1'b0;
      check({tag, "_hold_valid"}, o_valid, 1);
      check({tag, "_hold_sad"}, o_best_sad, bs);
      check({tag, "_hold_mvx"}, $signed(o_mv_x), bx);
    end
    i_ready = 1'b1;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    i_start = 1'b0;
    check({tag, "_accept_valid"}, o_valid, 0);
    check({tag, "_accept_busy"}, o_busy, 0);
    @(posedge i_clk);
    #1 check({tag, "_no_restart"}, o_busy, 0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_sad", o_best_sad, 0);
    check("rst_mvx", $signed(o_mv_x), 0);
    check("rst_r_row", o_r_row, 0);
    check("rst_s_row", o_s_row, 0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk);
    #1 check("idle_busy", o_busy, 0);

    fill(0, 1'b1, 3, -2);
    run("exact", 1'b0, 0);
    fill(1, 1'b0, 0, 0);
    run("flat", 1'b0, 0);
    fill(2, 1'b0, 0, 0);
    run("maxdiff", 1'b0, 0);
    fill(0, 1'b1, -5, -8);
    run("edge_place", 1'b0, 0);
    fill(3, 1'b0, 0, 0);
    run("ties", 1'b0, 0);
    fill(0, 1'b1, 3, -2);
    run("handshake", 1'b1, 20);

    // Reset in the middle of pass 5, pixel 100, then a clean rerun.
    fill(0, 1'b1, 3, -2);
    @(negedge i_clk);
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (5 * (NPIX + 1 + NPE) + 100) @(posedge i_clk);
    #1;
    check("mid_busy", o_busy, 1);
    check("mid_r_row", o_r_row, 100 / BLK);
    check("mid_r_col", o_r_col, 100 % BLK);
    check("mid_s_row", o_s_row, 5 + 100 / BLK);
    check("mid_s_col", o_s_col, 100 % BLK);
    #2 i_rst_n = 1'b0;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_valid", o_valid, 0);
    check("abort_sad", o_best_sad, 0);
    check("abort_s_row", o_s_row, 0);
    check("abort_r_col", o_r_col, 0);
    @(negedge i_clk) i_rst_n = 1'b1;
    run("after_rst", 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/me_sad_engine.md
Name: me_sad_engine

Overview:
- Parametrised full-search block-matching engine for the motion-estimation datapath.
- Computes the sum of absolute differences (SAD) of one BLK x BLK reference block against NPE x NY candidate positions and returns the best SAD and its signed motion vector.
- NPE processing elements each own one horizontal offset and work in parallel; vertical offsets are processed one pass at a time.
- Adds reset, a start/busy/valid/ready handshake and a defined tie-break.

Parameters:
- PIX_W, 8, pixel width in bits
- BLK, 16, block edge in pixels; must be a power of 2
- NPE, 16, horizontal positions (PE count); must be even
- NY, 16, vertical positions (passes); must be even
- MV_W, 8, signed motion-vector width
- Derived: LB = clog2(BLK); SAD_W = PIX_W + 2*LB; SR_W = clog2(BLK+NY-1)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_r_row  out  LB  reference read row
- o_r_col  out  LB  reference read column
- i_ref_pix  in  PIX_W  reference pixel; arrives one cycle after its address
- o_s_row  out  SR_W  search-window read row
- o_s_col  out  LB  search-window read start column
- i_search_win  in  NPE*PIX_W  search pixels (row, col..col+NPE-1); lane k is at bits [k*PIX_W +: PIX_W]; arrives one cycle after its address
- o_valid  out  1  result valid
- i_ready  in  1  result accepted
- o_best_sad  out  SAD_W  minimum SAD
- o_mv_x  out  MV_W  signed horizontal vector, equal to k - NPE/2
- o_mv_y  out  MV_W  signed vertical vector, equal to dy - NY/2

Behaviour:
- Reset: asynchronous on i_rst_n low. State goes to IDLE. All outputs are 0, all accumulators are 0, best register is all-ones, best_valid = 0.
- A reset during any state aborts the run; no partial result is ever presented.
- States: IDLE -> ACCUM -> FLUSH -> CMP -> (ACCUM of the next pass | DONE) -> IDLE.
- IDLE: i_start=1 clears the accumulators and sets dy=0 and best = all-ones; next state is ACCUM. i_start is ignored in every other state.
- ACCUM: lasts BLK*BLK cycles, indexed j = 0..BLK*BLK-1, row-major.
  - Cycle j drives o_r_row/o_r_col = (j/BLK, j%BLK), o_s_row = dy + j/BLK, o_s_col = j%BLK.
  - At the end of cycle j >= 1, PE k accumulates |ref - win[k]| for pixel j-1.
- FLUSH: 1 cycle; accumulates the last pixel.
- CMP: NPE cycles. Cycle k compares acc[k] < best using strict less-than. On a hit, best <= acc[k], mv <= (k - NPE/2, dy - NY/2), best_valid <= 1.
  - Scan order is dy ascending, then k ascending, so the earliest candidate wins any tie.
  - After CMP, accumulators clear. If dy < NY-1, increment dy and go to ACCUM; otherwise go to DONE.
- Pass length: BLK*BLK + 1 + NPE cycles.
- o_valid rises exactly NY*(BLK*BLK+1+NPE) clock edges after the edge that samples i_start (4368 at defaults).
- DONE: o_valid=1 and o_best_sad/o_mv_x/o_mv_y are held stable until an edge with i_ready=1. That edge returns to IDLE and drops o_valid. An i_start in the same cycle is ignored.
- Arithmetic: absolute difference is computed unsigned at PIX_W. Accumulators are SAD_W wide and cannot overflow, so there is no saturation.
- Address outputs are 0 outside ACCUM.

Optional Feature:
- Macro: ME_EARLY_TERM_EN.
- When defined, at the start of ACCUM cycle j >= 2, if best_valid=1 and every acc[k] >= best, the pass aborts. At the end of that cycle the engine skips FLUSH/CMP, clears the accumulators and moves to the next pass (or DONE). The in-flight read is discarded.
- An aborted pass therefore occupies j+1 cycles (minimum 3). Results are identical to the non-early-terminated run; only latency changes.
- When undefined: no comparison logic is built and latency is fixed as above.

Decomposition:
- Package me_pkg: state enum (IDLE, ACCUM, FLUSH, CMP, DONE) and width helper functions (SAD_W, SR_W).
- Sub-module me_sad_pe, instantiated NPE times via generate. Ports: i_clk, i_rst_n, i_clr, i_en, i_ref, i_srch, o_acc. Function: registered abs-diff accumulator.

Test Plan (defaults unless stated):
- Exact match: search equals ref placed at dx=+3, dy=-2, noise elsewhere -> o_valid at edge 4368; best_sad=0, mv=(3,-2).
- Flat images: all pixels 10 -> every SAD is 0 and the tie-break gives mv=(-8,-8), best_sad=0.
- Maximum difference: ref=255, search=0 -> best_sad=65280, mv=(-8,-8), no overflow.
- Handshake: i_ready held low 20 cycles after o_valid, with i_start pulsed during the run and during DONE -> outputs stable, o_valid held, no restart; i_ready=1 -> IDLE next edge.
- Reset at ACCUM pass 5, j=100 -> all outputs 0 immediately; a subsequent start yields the exact-match result at edge 4368.
- ME_EARLY_TERM_EN defined, exact match at dy=-8, non-zero SAD elsewhere -> 15 aborted passes of 3 cycles; o_valid at edge 273+45=318; best_sad=0, mv=(x,-8).
